// File: rtl/reg_file.sv
// MIPS general-purpose register file: 32 x 32-bit, two combinational read ports, one write port.
// Define REG_FILE_BYPASS_EN for same-cycle write-through on the read ports.
module reg_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;

  assign wr_en = reg_write && (write_reg != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (wr_en) begin
      regs[write_reg] <= write_data;
    end
  end

  // Zero override is applied last so address 0 and reset beat any bypassed value.
  always_comb begin
    read_data1 = regs[read_reg1];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && (read_reg1 == write_reg)) read_data1 = write_data;
`endif
    if (rst || (read_reg1 == '0)) read_data1 = '0;
  end

  always_comb begin
    read_data2 = regs[read_reg2];
`ifdef REG_FILE_BYPASS_EN
    if (wr_en && (read_reg2 == write_reg)) read_data2 = write_data;
`endif
    if (rst || (read_reg2 == '0)) read_data2 = '0;
  end

endmodule
